// File: rtl/prf_release_queue_pkg.sv
// ---------------------------------------------------------------------------
// prf_release_queue_pkg
//   Shared constants and types for the PRF release queue. The rename width
//   and PRF index width come from the rename macros; defaults are provided
//   here so the block builds stand-alone.
//   Contents:
//     RENAME_WIDTH, PRF_IDX_W, CP_IDX_W   rename-stage geometry
//     RELEASE_DEPTH                       default queue depth
//     release_ptr_t                       head/tail pointer with wrap bit
//     release_entry_t                     {has_dest, prf} queue entry
//     popCount()                          number of set lanes in a lane mask
// ---------------------------------------------------------------------------
`ifndef RENAME_WIDTH
`define RENAME_WIDTH 3
`endif
`ifndef PRF_INT_INDEX_SIZE
`define PRF_INT_INDEX_SIZE 6
`endif
`ifndef CP_INDEX_SIZE
`define CP_INDEX_SIZE 2
`endif

package prf_release_queue_pkg;

  localparam int RENAME_WIDTH  = `RENAME_WIDTH;
  localparam int PRF_IDX_W     = `PRF_INT_INDEX_SIZE;
  localparam int CP_IDX_W      = `CP_INDEX_SIZE;
  localparam int RELEASE_DEPTH = 32;
  localparam int PTR_W         = $clog2(RELEASE_DEPTH) + 1;
  localparam int COMMIT_W      = $clog2(RENAME_WIDTH + 1);

  typedef logic [PTR_W-1:0] release_ptr_t;

  typedef struct packed {
    logic                 has_dest;
    logic [PRF_IDX_W-1:0] prf;
  } release_entry_t;

  // Number of active lanes in a rename-width mask.
  function automatic logic [COMMIT_W-1:0] popCount(input logic [RENAME_WIDTH-1:0] lanes);
    logic [COMMIT_W-1:0] total;
    total = '0;
    for (int i = 0; i < RENAME_WIDTH; i++) begin
      total = total + COMMIT_W'(lanes[i]);
    end
    return total;
  endfunction

endpackage

// File: rtl/prf_release_queue_if.sv
// ---------------------------------------------------------------------------
// prf_release_queue_if
//   Rename/commit side bundle of the PRF release queue.
//   master: rename + commit logic (drives enqueue, commit, checkpoint,
//           recover; observes ready, releases and occupancy)
//   slave : the release queue itself
//   Signals:
//     enq_valid/enq_has_dest/enq_old_prf  per-lane stale mapping to enqueue
//     enq_ready                           room for a full rename group
//     commit_count                        oldest entries retiring this cycle
//     check/check_idx                     take a tail checkpoint
//     recover/recover_idx                 restore tail from a checkpoint
//     prf_replace_valid/prf_replace       per-lane release to the freelist
//     count                               occupancy
// ---------------------------------------------------------------------------
interface prf_release_queue_if #(
  parameter int DEPTH = prf_release_queue_pkg::RELEASE_DEPTH
);
  import prf_release_queue_pkg::*;

  logic [RENAME_WIDTH-1:0]                enq_valid;
  logic [RENAME_WIDTH-1:0]                enq_has_dest;
  logic [RENAME_WIDTH-1:0][PRF_IDX_W-1:0] enq_old_prf;
  logic                                   enq_ready;
  logic [COMMIT_W-1:0]                    commit_count;
  logic                                   check;
  logic [CP_IDX_W-1:0]                    check_idx;
  logic                                   recover;
  logic [CP_IDX_W-1:0]                    recover_idx;
  logic [RENAME_WIDTH-1:0]                prf_replace_valid;
  logic [RENAME_WIDTH-1:0][PRF_IDX_W-1:0] prf_replace;
  logic [$clog2(DEPTH):0]                 count;

  modport master (
    output enq_valid, enq_has_dest, enq_old_prf, commit_count,
           check, check_idx, recover, recover_idx,
    input  enq_ready, prf_replace_valid, prf_replace, count
  );

  modport slave (
    input  enq_valid, enq_has_dest, enq_old_prf, commit_count,
           check, check_idx, recover, recover_idx,
    output enq_ready, prf_replace_valid, prf_replace, count
  );

endinterface

// File: rtl/prf_release_queue_release_compactor.sv
// ---------------------------------------------------------------------------
// release_compactor
//   Purely combinational prefix sum over the enqueue lane mask. Each valid
//   lane is written at tail + o_offset[lane], so valid lanes land in
//   consecutive slots in ascending lane order with no holes.
//   Ports:
//     i_valid   per-lane enqueue valid
//     o_offset  number of valid lanes below each lane
//     o_total   number of valid lanes (tail advance)
// ---------------------------------------------------------------------------
module release_compactor
  import prf_release_queue_pkg::*;
(
  input  logic [RENAME_WIDTH-1:0]               i_valid,
  output logic [RENAME_WIDTH-1:0][COMMIT_W-1:0] o_offset,
  output logic [COMMIT_W-1:0]                   o_total
);

  logic [COMMIT_W-1:0] w_running;

  always_comb begin
    w_running = '0;
    o_offset  = '0;
    for (int i = 0; i < RENAME_WIDTH; i++) begin
      o_offset[i] = w_running;
      w_running   = w_running + COMMIT_W'(i_valid[i]);
    end
  end

  assign o_total = popCount(i_valid);

endmodule

// File: rtl/prf_release_queue.sv
// ---------------------------------------------------------------------------
// prf_release_queue
//   In-order queue of stale integer PRFs displaced at rename. Entries are
//   written compacted at the tail at rename, popped in order at commit and
//   returned to the integer freelist one cycle later through
//   prf_replace/prf_replace_valid. Tail checkpoints mirror the freelist so
//   that squashed instructions never release their stale registers.
//   Ports:
//     clock, reset   clock and synchronous active-high reset
//     io_rq          prf_release_queue_if.slave (enqueue, commit,
//                    checkpoint/recover, release outputs, occupancy)
//     stat_released  (RELEASE_QUEUE_STATS_EN) saturating count of released
//                    lanes that carried a destination
//     stat_squashed  (RELEASE_QUEUE_STATS_EN) entries discarded by recovers
//   Optional feature macro: RELEASE_QUEUE_STATS_EN
// ---------------------------------------------------------------------------
module prf_release_queue
  import prf_release_queue_pkg::*;
#(
  parameter int DEPTH  = RELEASE_DEPTH,
  parameter int CP_NUM = 2 ** CP_IDX_W
) (
  input  logic                   clock,
  input  logic                   reset,
  prf_release_queue_if.slave     io_rq
`ifdef RELEASE_QUEUE_STATS_EN
  ,
  output logic [31:0]            stat_released,
  output logic [31:0]            stat_squashed
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PW    = IDX_W + 1;

  release_entry_t                         r_mem [DEPTH];
  logic [PW-1:0]                          r_head;
  logic [PW-1:0]                          r_tail;
  logic [PW-1:0]                          r_cp [CP_NUM];
  logic [RENAME_WIDTH-1:0]                r_replaceValid;
  logic [RENAME_WIDTH-1:0][PRF_IDX_W-1:0] r_replace;

  logic [PW-1:0]                          w_count;
  logic                                   w_enqReady;
  logic                                   w_enqFire;
  logic [COMMIT_W-1:0]                    w_commitEff;
  logic [PW-1:0]                          w_headNext;
  logic [PW-1:0]                          w_tailAfterEnq;
  logic [PW-1:0]                          w_tailNext;
  logic [RENAME_WIDTH-1:0][COMMIT_W-1:0]  w_offset;
  logic [COMMIT_W-1:0]                    w_enqTotal;
  logic [RENAME_WIDTH-1:0][IDX_W-1:0]     w_wrAddr;
  logic [RENAME_WIDTH-1:0][IDX_W-1:0]     w_rdAddr;
  release_entry_t [RENAME_WIDTH-1:0]      w_wrData;
  logic [RENAME_WIDTH-1:0]                w_relValid;
  logic [RENAME_WIDTH-1:0][PRF_IDX_W-1:0] w_relPrf;

  release_compactor u_compactor (
    .i_valid  (io_rq.enq_valid),
    .o_offset (w_offset),
    .o_total  (w_enqTotal)
  );

  // Occupancy comes from the wrap-bit pointers; readiness uses only this
  // registered occupancy, so a same-cycle commit never frees room early.
  assign w_count    = r_tail - r_head;
  assign w_enqReady = (w_count <= PW'(DEPTH - RENAME_WIDTH));

  // A recovering cycle drops its enqueue group; the commit still happens
  // because committing instructions are older than the mispredicted branch.
  assign w_enqFire      = w_enqReady & ~io_rq.recover;
  assign w_commitEff    = (PW'(io_rq.commit_count) > w_count) ? w_count[COMMIT_W-1:0]
                                                              : io_rq.commit_count;
  assign w_headNext     = r_head + PW'(w_commitEff);
  assign w_tailAfterEnq = w_enqFire ? (r_tail + PW'(w_enqTotal)) : r_tail;
  assign w_tailNext     = io_rq.recover ? r_cp[io_rq.recover_idx] : w_tailAfterEnq;

  // Slot addresses for the compacted writes and the in-order reads of the
  // entries being popped, plus the release values those reads produce.
  always_comb begin
    w_wrAddr   = '0;
    w_rdAddr   = '0;
    w_wrData   = '0;
    w_relValid = '0;
    w_relPrf   = '0;
    for (int i = 0; i < RENAME_WIDTH; i++) begin
      w_wrAddr[i]          = IDX_W'(r_tail + PW'(w_offset[i]));
      w_rdAddr[i]          = IDX_W'(r_head + PW'(i));
      w_wrData[i].has_dest = io_rq.enq_has_dest[i];
      w_wrData[i].prf      = io_rq.enq_old_prf[i];
      if (i < int'(w_commitEff)) begin
        w_relValid[i] = r_mem[w_rdAddr[i]].has_dest;
        w_relPrf[i]   = r_mem[w_rdAddr[i]].prf;
      end
    end
  end

  // Entry storage needs no reset: only slots between head and tail are read.
  always_ff @(posedge clock) begin
    if (!reset && w_enqFire) begin
      for (int i = 0; i < RENAME_WIDTH; i++) begin
        if (io_rq.enq_valid[i]) begin
          r_mem[w_wrAddr[i]] <= w_wrData[i];
        end
      end
    end
  end

  // Pointers, checkpoints and the registered release port. A checkpoint
  // captures the tail after this cycle's enqueue so the branch's own group
  // survives a later recover; a simultaneous recover wins over a check.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_head         <= '0;
      r_tail         <= '0;
      r_replaceValid <= '0;
      r_replace      <= '0;
      for (int c = 0; c < CP_NUM; c++) begin
        r_cp[c] <= '0;
      end
    end else begin
      r_head         <= w_headNext;
      r_tail         <= w_tailNext;
      r_replaceValid <= w_relValid;
      r_replace      <= w_relPrf;
      if (io_rq.check && !io_rq.recover) begin
        r_cp[io_rq.check_idx] <= w_tailAfterEnq;
      end
    end
  end

  assign io_rq.enq_ready         = w_enqReady;
  assign io_rq.count             = w_count;
  assign io_rq.prf_replace_valid = r_replaceValid;
  assign io_rq.prf_replace       = r_replace;

`ifdef RELEASE_QUEUE_STATS_EN
  logic [31:0]         r_statReleased;
  logic [31:0]         r_statSquashed;
  logic [COMMIT_W-1:0] w_relCount;
  logic [PW-1:0]       w_squashCount;

  assign w_relCount    = popCount(w_relValid);
  assign w_squashCount = r_tail - r_cp[io_rq.recover_idx];

  // Released lanes are counted on the edge that presents them; squashed
  // entries are everything between the old tail and the restored tail.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_statReleased <= '0;
      r_statSquashed <= '0;
    end else begin
      if (r_statReleased > (32'hFFFF_FFFF - 32'(w_relCount))) begin
        r_statReleased <= '1;
      end else begin
        r_statReleased <= r_statReleased + 32'(w_relCount);
      end
      if (io_rq.recover) begin
        r_statSquashed <= r_statSquashed + 32'(w_squashCount);
      end
    end
  end

  assign stat_released = r_statReleased;
  assign stat_squashed = r_statSquashed;
`endif

  // Protocol checks: an enqueue without room is dropped, and an
  // over-sized commit is clamped; both point to a bug upstream.
  always @(posedge clock) begin
    if (!reset) begin
      assert (!((|io_rq.enq_valid) && !w_enqReady))
        else $warning("prf_release_queue: enqueue while enq_ready low was dropped");
      assert (PW'(io_rq.commit_count) <= w_count)
        else $warning("prf_release_queue: commit_count above occupancy was clamped");
    end
  end

endmodule

// File: tb/tb_prf_release_queue.sv
// ---------------------------------------------------------------------------
// tb_prf_release_queue
//   Directed bench for prf_release_queue. A queue-based model of the release
//   queue predicts occupancy, readiness and the release port every cycle;
//   directed sequences add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_prf_release_queue;
  import prf_release_queue_pkg::*;

  localparam int RW     = RENAME_WIDTH;
  localparam int DEPTH  = RELEASE_DEPTH;
  localparam int CP_NUM = 2 ** CP_IDX_W;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   compared   = 0;
  int   mismatched = 0;

  prf_release_queue_if #(.DEPTH(DEPTH)) rq ();

`ifdef RELEASE_QUEUE_STATS_EN
  logic [31:0] statReleased;
  logic [31:0] statSquashed;
`endif

  prf_release_queue #(.DEPTH(DEPTH), .CP_NUM(CP_NUM)) dut (
    .clock (clock),
    .reset (reset),
    .io_rq (rq)
`ifdef RELEASE_QUEUE_STATS_EN
    ,
    .stat_released (statReleased),
    .stat_squashed (statSquashed)
`endif
  );

  always #5 clock = ~clock;

  // Comparison helper shared by the per-cycle checker and directed checks.
  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference model: an ordered list of entries plus absolute enqueue and
  // pop totals; checkpoints remember how many entries had ever been kept.
  release_entry_t                  modelQ[$];
  release_entry_t                  mEnt;
  int                              cpAbs [CP_NUM];
  int                              enqAbs;
  int                              popAbs;
  int                              mSize;
  int                              mPops;
  int                              mKeep;
  bit                              mReady;
  bit                              modelLive = 1'b0;
  logic [RW-1:0]                   expValid;
  logic [RW-1:0]                   expPopped;
  logic [RW-1:0][PRF_IDX_W-1:0]    expPrf;
  int                              expReleased;
  int                              expSquashed;

  always @(posedge clock) begin
    if (reset) begin
      modelQ.delete();
      enqAbs      = 0;
      popAbs      = 0;
      expValid    = '0;
      expPopped   = '0;
      expPrf      = '0;
      expReleased = 0;
      expSquashed = 0;
      for (int c = 0; c < CP_NUM; c++) cpAbs[c] = 0;
      modelLive   = 1'b1;
    end else begin
      mSize     = modelQ.size();
      mReady    = (DEPTH - mSize) >= RW;
      mPops     = (int'(rq.commit_count) > mSize) ? mSize : int'(rq.commit_count);
      expValid  = '0;
      expPopped = '0;
      expPrf    = '0;
      for (int i = 0; i < mPops; i++) begin
        mEnt         = modelQ.pop_front();
        expPopped[i] = 1'b1;
        expValid[i]  = mEnt.has_dest;
        expPrf[i]    = mEnt.prf;
        if (mEnt.has_dest) expReleased++;
        popAbs++;
      end
      if (rq.recover) begin
        mKeep = cpAbs[rq.recover_idx] - popAbs;
        while (modelQ.size() > mKeep) begin
          modelQ.delete(modelQ.size() - 1);
          expSquashed++;
        end
        enqAbs = cpAbs[rq.recover_idx];
      end else begin
        if (mReady) begin
          for (int i = 0; i < RW; i++) begin
            if (rq.enq_valid[i]) begin
              mEnt.has_dest = rq.enq_has_dest[i];
              mEnt.prf      = rq.enq_old_prf[i];
              modelQ.push_back(mEnt);
              enqAbs++;
            end
          end
        end
        if (rq.check) cpAbs[rq.check_idx] = enqAbs;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (modelLive) begin
      checkOutput("count", int'(rq.count), modelQ.size());
      checkOutput("enq_ready", int'(rq.enq_ready), int'((DEPTH - modelQ.size()) >= RW));
      checkOutput("release_valid", int'(rq.prf_replace_valid), int'(expValid));
      for (int i = 0; i < RW; i++) begin
        if (expPopped[i]) checkOutput("release_prf", int'(rq.prf_replace[i]), int'(expPrf[i]));
      end
`ifdef RELEASE_QUEUE_STATS_EN
      checkOutput("stat_released", int'(statReleased), expReleased);
      checkOutput("stat_squashed", int'(statSquashed), expSquashed);
`endif
    end
  end

  function automatic logic [RW-1:0][PRF_IDX_W-1:0] prfs(input int p0, input int p1, input int p2);
    logic [RW-1:0][PRF_IDX_W-1:0] v;
    v    = '0;
    v[0] = PRF_IDX_W'(p0);
    v[1] = PRF_IDX_W'(p1);
    v[2] = PRF_IDX_W'(p2);
    return v;
  endfunction

  // Drive one cycle of inputs just after the falling edge.
  task automatic applyStimulus(input logic [RW-1:0] valid, input logic [RW-1:0] hasDest,
                               input logic [RW-1:0][PRF_IDX_W-1:0] oldPrf, input int commitCnt,
                               input bit chk, input int chkIdx, input bit rec, input int recIdx);
    @(negedge clock);
    rq.enq_valid    = valid;
    rq.enq_has_dest = hasDest;
    rq.enq_old_prf  = oldPrf;
    rq.commit_count = COMMIT_W'(commitCnt);
    rq.check        = chk;
    rq.check_idx    = CP_IDX_W'(chkIdx);
    rq.recover      = rec;
    rq.recover_idx  = CP_IDX_W'(recIdx);
  endtask

  task automatic applyIdle();
    applyStimulus('0, '0, '0, 0, 1'b0, 0, 1'b0, 0);
  endtask

  task automatic applyEnq(input logic [RW-1:0] valid, input logic [RW-1:0] hasDest,
                          input logic [RW-1:0][PRF_IDX_W-1:0] oldPrf);
    applyStimulus(valid, hasDest, oldPrf, 0, 1'b0, 0, 1'b0, 0);
  endtask

  task automatic applyCommit(input int n);
    applyStimulus('0, '0, '0, n, 1'b0, 0, 1'b0, 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rq.enq_valid    = '0;
    rq.enq_has_dest = '0;
    rq.enq_old_prf  = '0;
    rq.commit_count = '0;
    rq.check        = 1'b0;
    rq.check_idx    = '0;
    rq.recover      = 1'b0;
    rq.recover_idx  = '0;

    // Reset for two cycles, then the queue must be empty and quiet.
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    checkOutput("reset_count", int'(rq.count), 0);
    checkOutput("reset_ready", int'(rq.enq_ready), 1);
    checkOutput("reset_valid", int'(rq.prf_replace_valid), 0);
    repeat (3) applyIdle();
    checkOutput("idle_valid", int'(rq.prf_replace_valid), 0);

    // Full group of three, released as two then one.
    applyEnq(3'b111, 3'b111, prfs(5, 7, 9));
    applyCommit(2);
    checkOutput("grp_count", int'(rq.count), 3);
    applyCommit(1);
    checkOutput("rel2_valid", int'(rq.prf_replace_valid), 3'b011);
    checkOutput("rel2_lane0", int'(rq.prf_replace[0]), 5);
    checkOutput("rel2_lane1", int'(rq.prf_replace[1]), 7);
    applyIdle();
    checkOutput("rel1_valid", int'(rq.prf_replace_valid), 3'b001);
    checkOutput("rel1_lane0", int'(rq.prf_replace[0]), 9);
    checkOutput("rel1_count", int'(rq.count), 0);
    applyIdle();
    checkOutput("rel_oneshot", int'(rq.prf_replace_valid), 0);

    // Sparse lanes compact; has_dest=0 masks the release.
    applyEnq(3'b101, 3'b100, prfs(12, 0, 13));
    applyCommit(2);
    checkOutput("cmp_count", int'(rq.count), 2);
    applyIdle();
    checkOutput("cmp_valid", int'(rq.prf_replace_valid), 3'b010);
    checkOutput("cmp_lane1", int'(rq.prf_replace[1]), 13);

    // Fill to 30 entries; the eleventh group is dropped.
    for (int g = 0; g < 10; g++) applyEnq(3'b111, 3'b111, prfs(3 * g, 3 * g + 1, 3 * g + 2));
    applyEnq(3'b111, 3'b111, prfs(60, 61, 62));
    checkOutput("full_count", int'(rq.count), 30);
    checkOutput("full_ready", int'(rq.enq_ready), 0);
    applyCommit(3);
    checkOutput("drop_count", int'(rq.count), 30);
    applyIdle();
    checkOutput("drain_count", int'(rq.count), 27);
    checkOutput("drain_ready", int'(rq.enq_ready), 1);
    checkOutput("drain_lane2", int'(rq.prf_replace[2]), 2);
    repeat (9) applyCommit(3);
    applyIdle();
    checkOutput("empty_count", int'(rq.count), 0);
    checkOutput("last_lane2", int'(rq.prf_replace[2]), 29);

    // Checkpoint includes its own group; recover squashes younger entries
    // and drops the same-cycle enqueue.
    applyEnq(3'b111, 3'b111, prfs(20, 21, 22));
    applyStimulus(3'b011, 3'b011, prfs(23, 24, 0), 0, 1'b1, 1, 1'b0, 0);
    checkOutput("cp_pre_count", int'(rq.count), 3);
    applyEnq(3'b111, 3'b111, prfs(25, 26, 27));
    checkOutput("cp_count", int'(rq.count), 5);
    applyStimulus(3'b111, 3'b111, prfs(40, 41, 42), 0, 1'b0, 0, 1'b1, 1);
    checkOutput("pre_rec_count", int'(rq.count), 8);
    applyCommit(3);
    checkOutput("rec_count", int'(rq.count), 5);
    applyCommit(2);
    checkOutput("rec_rel_valid", int'(rq.prf_replace_valid), 3'b111);
    checkOutput("rec_rel_lane0", int'(rq.prf_replace[0]), 20);
    checkOutput("rec_rel_lane2", int'(rq.prf_replace[2]), 22);
    applyIdle();
    checkOutput("rec_tail_valid", int'(rq.prf_replace_valid), 3'b011);
    checkOutput("rec_tail_lane1", int'(rq.prf_replace[1]), 24);
    checkOutput("rec_end_count", int'(rq.count), 0);
    applyIdle();
    checkOutput("no_squash_rel", int'(rq.prf_replace_valid), 0);

    // Streaming enqueue/commit across the pointer wrap.
    for (int k = 0; k < 40; k++) begin
      applyStimulus(3'b111, 3'b111, prfs((3 * k) % 64, (3 * k + 1) % 64, (3 * k + 2) % 64),
                    (k > 0) ? 3 : 0, 1'b0, 0, 1'b0, 0);
    end
    applyCommit(3);
    applyIdle();
    checkOutput("wrap_lane0", int'(rq.prf_replace[0]), 53);
    checkOutput("wrap_lane2", int'(rq.prf_replace[2]), 55);
    checkOutput("wrap_count", int'(rq.count), 0);
    repeat (2) applyIdle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/prf_release_queue.md
Name: prf_release_queue

Overview:
- In-order queue of stale integer physical registers, i.e. the old mappings displaced at rename.
- Written at rename, one slot per renamed instruction, up to `RENAME_WIDTH per cycle.
- Drained at commit. Released registers go to freelist_int through its prf_replace/prf_replace_valid port; this block is the producer end of that return path.
- Mirrors the freelist checkpoint/recover interface, so squashed instructions never release their stale registers.

Parameters:
- DEPTH, 32, number of entries; power of 2, at least 2*`RENAME_WIDTH.
- CP_NUM, 2**`CP_INDEX_SIZE, number of tail checkpoints.

Ports:
- clock  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- enq_valid  in  `RENAME_WIDTH  per-lane renamed instruction present.
- enq_has_dest  in  `RENAME_WIDTH  per-lane: instruction overwrote a mapping.
- enq_old_prf  in  `RENAME_WIDTH x `PRF_INT_INDEX_SIZE  displaced PRF per lane.
- enq_ready  out  1  at least `RENAME_WIDTH free slots.
- commit_count  in  $clog2(`RENAME_WIDTH+1)  oldest instructions committing this cycle.
- check  in  1  take tail checkpoint.
- check_idx  in  `CP_INDEX_SIZE  checkpoint slot to write.
- recover  in  1  restore tail from checkpoint.
- recover_idx  in  `CP_INDEX_SIZE  checkpoint slot to read.
- prf_replace_valid  out  `RENAME_WIDTH  per-lane release valid.
- prf_replace  out  `RENAME_WIDTH x `PRF_INT_INDEX_SIZE  released PRF per lane.
- count  out  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Reset: head=tail=0, count=0, enq_ready=1, prf_replace_valid=0, prf_replace=0. Checkpoint slots are cleared to 0.
- Reset mid-operation discards all entries.
- Pointers are $clog2(DEPTH)+1 bits with a wrap bit; count = tail-head modulo 2*DEPTH.
- enq_ready is combinational from registered count: ready when DEPTH-count >= `RENAME_WIDTH.
- Enqueue, effective only when enq_ready=1:
  - Lanes with enq_valid=1 are written in ascending lane order, compacted, at tail, tail+1, and so on.
  - Each entry stores {has_dest, old_prf}.
  - enq_valid while enq_ready=0 is ignored, and an assertion fires.
- Commit:
  - The commit_count oldest entries are popped this cycle.
  - Next cycle: prf_replace[i] = old_prf of popped entry i, and prf_replace_valid[i] = has_dest of that entry.
  - Lanes i >= commit_count show valid 0.
  - Outputs are registered: commit at cycle t gives release at t+1, and they are valid for exactly one cycle.
  - commit_count > count is clamped to count, and an assertion fires.
- Checkpoint: check=1 stores into cp[check_idx] the tail value after this cycle's enqueues, so the branch's own group is included.
- Recover:
  - recover=1 sets tail = cp[recover_idx]; squashed entries are discarded without release.
  - Same-cycle enqueue is dropped.
  - Same-cycle commit is still performed, because committing instructions are older than the branch.
  - New count = cp tail minus post-commit head.
- check and recover in the same cycle: recover takes effect, and check is ignored.
- Wrap-around: pointers index modulo DEPTH and order is preserved across the wrap.
- Full: enqueue and commit in the same cycle are both legal; enq_ready is based on registered count only, with no same-cycle credit.

Optional Feature:
- Macro: RELEASE_QUEUE_STATS_EN.
- Defined: adds output stat_released (32 bits), which counts released lanes with has_dest=1, saturating. Also adds output stat_squashed (32 bits), which accumulates the entries discarded on each recover. Both reset to 0.
- Undefined: neither port nor counter exists, and behaviour is otherwise identical.

Decomposition:
- Shared package (alongside the existing rename constants):
  - typedef release_entry_t {logic has_dest; logic [`PRF_INT_INDEX_SIZE-1:0] prf;}
  - pointer typedef sized from DEPTH
  - RELEASE_DEPTH constant
- Sub-module release_compactor: combinational mapping from enq_valid to per-lane write offsets (prefix sum). This is the only natural split; the storage and pointer logic stay in the top.

Test Plan:
- Reset held 2 cycles -> enq_ready=1, count=0, prf_replace_valid=3'b000 and stays 0 with no stimulus.
- Enqueue lanes 111, old_prf {5,7,9}, has_dest 111; then commit_count=2 -> one cycle later prf_replace lane0=5, lane1=7, valid 3'b011. Then commit_count=1 -> lane0=9, valid 3'b001, count=0.
- Enqueue enq_valid 3'b101, lane0 {has_dest 0, prf 12}, lane2 {1, 13}; commit_count=2 -> valid 3'b010, lane1=13, which confirms compaction and has_dest masking.
- DEPTH=32: ten enqueue groups of 3 -> count=30, enq_ready=0, and an eleventh group is ignored. commit_count=3 -> count=27 and enq_ready=1 the following cycle.
- Enqueue 3 (tail 3). Then check=1, check_idx=1 with 2 more enqueued the same cycle -> cp=5. Enqueue 3 more -> count=8. recover=1, recover_idx=1 -> count=5. Commit 5 -> only the first 5 PRFs are released.
- 40 enqueue/commit pairs of 3 with PRF values 0..119 mod 64 -> pointers wrap past 32, and releases appear in exactly enqueue order.
